// File: rtl/md_defs_pkg.sv
// md_defs_pkg: shared op encodings, cycle defaults and counter width
// for the HI/LO multiply/divide unit.
package md_defs_pkg;

    localparam int CNT_W = 4;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MADD  = 3'd6,
        MD_MADDU = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } md_state_e;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc: combinational multiply / divide / accumulate datapath.
// MADD/MADDU accumulate only exists when MD_MADD_EN is defined.
module md_calc
    import md_defs_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] res,
    output logic        div0
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sgn;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes so INT_MIN / -1 wraps cleanly.
    assign sgn     = (op == MD_DIV);
    assign a_neg   = sgn & a[31];
    assign b_neg   = sgn & b[31];
    assign a_mag   = a_neg ? (~a + 32'd1) : a;
    assign b_mag   = b_neg ? (~b + 32'd1) : b;
    assign div0    = is_div_op(op) && (b == 32'd0);
    assign b_safe  = (b == 32'd0) ? 32'd1 : b_mag;
    assign quo_mag = a_mag / b_safe;
    assign rem_mag = a_mag % b_safe;
    assign quo     = (a_neg ^ b_neg) ? (~quo_mag + 32'd1) : quo_mag;
    assign rem     = a_neg ? (~rem_mag + 32'd1) : rem_mag;

`ifdef MD_MADD_EN
    logic [63:0] acc;
    assign acc = {hi, lo};
`else
    logic unused_acc;
    assign unused_acc = ^{hi, lo};
`endif

    always_comb begin
        res = 64'd0;
        case (op)
            MD_MULT:  res = prod_s;
            MD_MULTU: res = prod_u;
            MD_DIV:   res = {rem, quo};
            MD_DIVU:  res = {rem, quo};
`ifdef MD_MADD_EN
            MD_MADD:  res = acc + prod_s;
            MD_MADDU: res = acc + prod_u;
`endif
            default:  res = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: HI/LO owner; multi-cycle MULT/DIV with busy for D-stage stall.
// Optional MADD/MADDU accumulate is enabled by defining MD_MADD_EN.
module md_unit
    import md_defs_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

    md_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      pend;
    logic             pend_skip;
    logic [63:0]      calc_res;
    logic             calc_div0;
    logic             is_mul;
    logic             is_div;

    md_calc u_calc (
        .op   (op),
        .a    (a),
        .b    (b),
        .hi   (hi),
        .lo   (lo),
        .res  (calc_res),
        .div0 (calc_div0)
    );

`ifdef MD_MADD_EN
    assign is_mul = (op == MD_MULT) || (op == MD_MULTU)
                 || (op == MD_MADD) || (op == MD_MADDU);
`else
    assign is_mul = (op == MD_MULT) || (op == MD_MULTU);
`endif
    assign is_div = is_div_op(op);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            pend      <= '0;
            pend_skip <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        unique case (1'b1)
                            is_mul: begin
                                pend      <= calc_res;
                                pend_skip <= 1'b0;
                                cnt       <= MULT_N;
                                busy      <= 1'b1;
                                state     <= ST_RUN;
                            end
                            is_div: begin
                                pend      <= calc_res;
                                pend_skip <= calc_div0;
                                cnt       <= DIV_N;
                                busy      <= 1'b1;
                                state     <= ST_RUN;
                            end
                            (op == MD_MTHI): hi <= a;
                            (op == MD_MTLO): lo <= a;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        if (!pend_skip) begin
                            hi <= pend[63:32];
                            lo <= pend[31:0];
                        end
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit with a longint reference model.
// Define MD_MADD_EN for both bench and RTL to cover the accumulate ops.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: on each busy fall, pop the expected commit and compare.
    int   bcnt = 0;
    logic pbusy = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            sbq.delete();
            bcnt  = 0;
            pbusy = 1'b0;
        end else begin
            if (busy) begin
                bcnt++;
            end else if (pbusy) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_commit: got hi=%h lo=%h want none",
                             hi, lo);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check({e.name, "_hi"}, hi, e.hi);
                    check({e.name, "_lo"}, lo, e.lo);
                    check({e.name, "_busy_len"}, 32'(bcnt), 32'(e.cyc));
                end
                bcnt = 0;
            end
            pbusy = busy;
        end
    end

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got busy after %0d cycles want idle", nm, n);
        end
        @(negedge clk);
        check({nm, "_sb_empty"}, 32'(sbq.size()), 32'd0);
    endtask

    // Issue one op; model decides expected hi/lo and whether it runs long.
    task automatic issue(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input string nm,
                         input int inj, input int rst_at);
        longint          sx, sy, q, r;
        longint unsigned ux, uy;
        logic [63:0]     p;
        bit              lng;
        int              cyc;
        exp_t            e;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        lng = 1'b0;
        cyc = 0;
        case (o)
            3'd0: begin p = 64'(sx * sy); {m_hi, m_lo} = p; lng = 1; cyc = MC; end
            3'd1: begin p = ux * uy; {m_hi, m_lo} = p; lng = 1; cyc = MC; end
            3'd2: begin
                if (y != 0) begin
                    q = sx / sy;
                    r = sx % sy;
                    m_lo = 32'(q);
                    m_hi = 32'(r);
                end
                lng = 1; cyc = DC;
            end
            3'd3: begin
                if (y != 0) begin
                    m_lo = 32'(ux / uy);
                    m_hi = 32'(ux % uy);
                end
                lng = 1; cyc = DC;
            end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
`ifdef MD_MADD_EN
            3'd6: begin p = {m_hi, m_lo} + 64'(sx * sy); {m_hi, m_lo} = p; lng = 1; cyc = MC; end
            3'd7: begin p = {m_hi, m_lo} + ux * uy; {m_hi, m_lo} = p; lng = 1; cyc = MC; end
`endif
            default: ;
        endcase
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (lng) begin
            e.hi = m_hi; e.lo = m_lo; e.cyc = cyc; e.name = nm;
            sbq.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        if (!lng) begin
            check({nm, "_nobusy"}, 32'(busy), 32'd0);
            check({nm, "_hi"}, hi, m_hi);
            check({nm, "_lo"}, lo, m_lo);
            return;
        end
        if (inj > 0) begin
            repeat (inj - 1) @(negedge clk);
            start = 1'b1;
            op    = 3'd4;
            a     = 32'h0000ABCD;
            @(negedge clk);
            start = 1'b0;
        end
        if (rst_at > 0) begin
            repeat (rst_at - 1) @(negedge clk);
            reset = 1'b0;
            m_hi  = 0;
            m_lo  = 0;
            #1;
            check({nm, "_rst_busy"}, 32'(busy), 32'd0);
            check({nm, "_rst_hi"}, hi, 32'd0);
            check({nm, "_rst_lo"}, lo, 32'd0);
            @(negedge clk);
            @(negedge clk);
            reset = 1'b1;
            repeat (15) @(negedge clk);
            check({nm, "_post_busy"}, 32'(busy), 32'd0);
            check({nm, "_post_hi"}, hi, 32'd0);
            check({nm, "_post_lo"}, lo, 32'd0);
            return;
        end
        wait_idle(nm);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        issue(3'd0, 32'hFFFFFFFE, 32'd3, "mult", 0, 0);
        check("mult_hi_const", hi, 32'hFFFFFFFF);
        check("mult_lo_const", lo, 32'hFFFFFFFA);
        issue(3'd1, 32'hFFFFFFFE, 32'd3, "multu", 0, 0);
        check("multu_hi_const", hi, 32'h00000002);
        issue(3'd2, 32'hFFFFFFF9, 32'd2, "div", 0, 0);
        check("div_lo_const", lo, 32'hFFFFFFFD);
        check("div_hi_const", hi, 32'hFFFFFFFF);
        issue(3'd3, 32'd7, 32'd2, "divu", 0, 0);
        check("divu_lo_const", lo, 32'd3);
        check("divu_hi_const", hi, 32'd1);
        issue(3'd4, 32'h11, 32'd0, "mthi", 0, 0);
        issue(3'd5, 32'h22, 32'd0, "mtlo", 0, 0);
        issue(3'd3, 32'd5, 32'd0, "divu0", 0, 0);
        check("divu0_hi_const", hi, 32'h11);
        check("divu0_lo_const", lo, 32'h22);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf", 0, 0);
        check("div_ovf_lo_const", lo, 32'h80000000);
        issue(3'd0, 32'h12345678, 32'h9ABCDEF0, "mult_inj", 2, 0);
        issue(3'd4, 32'd0, 32'd0, "mthi0", 0, 0);
        issue(3'd5, 32'hFFFFFFFF, 32'd0, "mtlo1", 0, 0);
        issue(3'd7, 32'd1, 32'd1, "op7", 0, 0);
        issue(3'd6, 32'hFFFFFFFF, 32'd3, "op6", 0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            issue(ro, ra, rb, $sformatf("rnd%0d", i), 0, 0);
        end

        issue(3'd2, 32'd100, 32'd7, "div_rst", 0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide responder for the 5-stage MIPS pipeline. It owns the HI/LO registers.
- The E stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO as a one-cycle start request.
- The unit answers with a busy flag that D-stage stall logic consumes (alubusy_E path) and a combinational HI/LO read path for MFHI/MFLO.
- Sits beside the ALU in E; the result leaves through E_M like ALU output.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD/MADDU when enabled), range 1..15.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU, range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle operation request from E stage.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD*, 7 MADDU* (*feature only).
- a  in  32  rs operand, already forwarded.
- b  in  32  rt operand, already forwarded.
- busy  out  1  operation in flight; registered.
- hi  out  32  architectural HI, registered.
- lo  out  32  architectural LO, registered.

Behaviour:
- Reset (reset==0, any time, including mid-operation): busy=0, hi=0, lo=0, counter=0, pending result discarded.
- States: IDLE (busy=0), RUN (busy=1). The counter is 4 bits.
- IDLE with start and op in 0..3:
  - compute the result into pending_hi/pending_lo at that edge;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - busy=1 from the next cycle.
- RUN: counter decrements each edge. On the edge where counter==1: hi/lo <= pending, busy <= 0, return to IDLE.
  - busy is high for exactly N cycles.
  - The new hi/lo is visible in the cycle busy first reads 0.
- MTHI/MTLO in IDLE: hi (resp. lo) <= a at that edge; no busy; other register unchanged.
- start while busy is ignored: no state change, hi/lo untouched. The pipeline guarantees this never happens because D stalls any MD instruction when busy|start.
- MULT: signed 64-bit product of a*b, hi=[63:32], lo=[31:0]. MULTU: the same, unsigned.
- DIV:
  - signed; lo=quotient truncated toward zero; hi=remainder with the sign of the dividend;
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned; lo=a/b, hi=a%b.
- Divide by zero (b==0): full busy period runs, hi/lo are left unchanged at commit.
- Ops 6/7 with the feature disabled: treated as no-op, no busy.
- hi/lo outputs always reflect committed values only. Pending results are never exposed.

Optional Feature:
- MD_MADD_EN defined: op 6 MADD is the signed {hi,lo} += a*b (64-bit wrap); op 7 MADDU is the same, unsigned. Both use MULT_CYCLES.
  - The accumulate reads hi/lo as committed at the start edge.
- Undefined: ops 6/7 are no-ops; no accumulate logic is synthesized.

Decomposition:
- Shared package/header md_defs: op encodings (MD_MULT..MD_MADDU), default cycle counts, 4-bit counter width constant.
- One sub-module, md_calc: purely combinational. Inputs op, a, b, hi, lo. Outputs 64-bit pending result and a div0 flag.
- md_unit holds the FSM, counter and HI/LO registers.

Test Plan:
- Reset mid-DIV: start DIV 100/7, drop reset on cycle 3 -> busy=0, hi=0, lo=0 immediately; no commit afterwards.
- MULT 0xFFFFFFFE * 3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV -7/2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
- Preload hi=0x11, lo=0x22 via MTHI/MTLO (no busy either time), then DIVU 5/0 -> busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- Start MULT, then pulse start with MTHI a=0xABCD on busy cycle 2 -> ignored; final hi/lo equal the MULT result.
- With MD_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU 1*1 -> hi=1, lo=0. Without it, op 6 leaves busy=0 and hi/lo unchanged.
